// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and hex decoder for the 7-segment scan controller
package seg7_pkg;

  localparam int WORD_W = 16;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_NEXT
  } ctrl_state_e;

  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  function automatic logic [6:0] hexdecode(input logic [3:0] h);
    case (h)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - host-side write/commit/status bundle of the scan controller
interface seg7_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic       commit;
  logic       blank;
  logic       commit_pending;
  logic       commit_ack;
  logic       frame_start;

  modport master (
    output wr_en, wr_addr, wr_data, commit, blank,
    input  commit_pending, commit_ack, frame_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, blank,
    output commit_pending, commit_ack, frame_start
  );
endinterface

// File: rtl/hc595_shifter.sv
// rtl/hc595_shifter.sv - serialises one word LSB first into a 74HC595 chain, then pulses the latch
module hc595_shifter
  import seg7_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ser,
  output logic              rclk
);

  localparam logic [5:0] LATCH_PH = 6'(2 * WORD_W);

  logic [WORD_W-1:0] sr;
  logic [5:0]        ph;
  logic              fin;

  // ph walks two phases per bit, then the latch-high and latch-low ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      ph   <= '0;
      fin  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      ser  <= 1'b0;
      rclk <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          sr   <= word;
          ph   <= '0;
          busy <= 1'b1;
        end
      end else if (fin) begin
        fin  <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (tick) begin
        ph <= ph + 6'd1;
        if (ph < LATCH_PH) begin
          if (!ph[0]) begin
            sclk <= 1'b0;
            ser  <= sr[0];
            sr   <= sr >> 1;
          end else begin
            sclk <= 1'b1;
          end
        end else if (ph == LATCH_PH) begin
          sclk <= 1'b0;
          rclk <= 1'b1;
        end else begin
          rclk <= 1'b0;
          fin  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - tear-free 8-digit 7-segment refresh controller over cascaded 74HC595s
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 12500,
  parameter int NUM_DIGITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_scan_ctrl_if.slave host,
  output logic          sclk,
  output logic          ser,
  output logic          rclk,
  output logic          srclr_n
);

  localparam int         CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  digit_t        shadow [NUM_DIGITS];
  digit_t        active [NUM_DIGITS];
  digit_t        cur;
  logic          pending_q;
  ctrl_state_e   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          start, swap, fs;
  logic [7:0]    seg, dig_n;
  logic          sh_busy, sh_done;

  assign tick = (tick_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) srclr_n <= 1'b0;
    else srclr_n <= 1'b1;
  end

  // The swap copies the pre-edge shadow, so a same-cycle write lands only in the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (host.wr_en) shadow[host.wr_addr] <= digit_t'(host.wr_data);
      if (swap) active <= shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= 1'b0;
    else if (host.commit) pending_q <= 1'b1;
    else if (swap) pending_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start   = 1'b0;
    fs      = 1'b0;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        start   = 1'b1;
        fs      = (idx_q == 3'd0);
        state_d = ST_WAIT;
      end
      ST_WAIT: if (sh_done) state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          swap  = pending_q;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
        state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cur   = active[idx_q];
  assign seg   = (host.blank || !cur.en) ? 8'h00 : {cur.dp, hexdecode(cur.hex)};
  assign dig_n = ~(8'b1 << idx_q);

  assign host.commit_pending = pending_q;
  assign host.commit_ack     = swap;
  assign host.frame_start    = fs;

  hc595_shifter u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .start (start),
    .word  ({seg, dig_n}),
    .busy  (sh_busy),
    .done  (sh_done),
    .sclk  (sclk),
    .ser   (ser),
    .rclk  (rclk)
  );

  logic unused_busy;
  assign unused_busy = sh_busy;

endmodule
